// File: rtl/input_port_fifo_if.sv
// Handshake and status bundle between the external producer / processor and input_port_fifo.
// Master drives the producer data and the processor read strobe; slave is the FIFO.
interface input_port_fifo_if #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] ext_data;
    logic             ext_valid;
    logic             ext_ready;
    logic             rd_en;
    logic [WIDTH-1:0] getin;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             underflow;

    modport master (
        output ext_data, ext_valid, rd_en,
        input  ext_ready, getin, empty, full, count, underflow
    );

    modport slave (
        input  ext_data, ext_valid, rd_en,
        output ext_ready, getin, empty, full, count, underflow
    );
endinterface

// File: rtl/input_port_fifo.sv
// Input-port FIFO feeding the processor stack-input mux (getin), zero-cycle read latency.
// Optional sticky read-while-empty flag enabled by macro INPORT_UNDERFLOW_EN.
module input_port_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input logic                CLK,
    input logic                reset,
    input_port_fifo_if.slave   port
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Reset gates ready so no word is ever accepted on a reset edge.
    assign port.ext_ready = !full && !reset;
    assign push = port.ext_valid && port.ext_ready;
    assign pop  = port.rd_en && !empty && !reset;

    // Storage is left uncleared on reset; the pointers alone define contents.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= port.ext_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef INPORT_UNDERFLOW_EN
    logic underflow_q;

    always_ff @(posedge CLK) begin
        if (reset) begin
            underflow_q <= 1'b0;
        end else if (port.rd_en && empty) begin
            underflow_q <= 1'b1;
        end
    end

    assign port.underflow = underflow_q;
`else
    assign port.underflow = 1'b0;
`endif

    assign port.getin = empty ? '0 : mem[rd_ptr];
    assign port.empty = empty;
    assign port.full  = full;
    assign port.count = count_q;
endmodule

// File: tb/tb_input_port_fifo.sv
// Directed self-checking bench for input_port_fifo (DEPTH=16, WIDTH=16).
// Underflow expectation follows INPORT_UNDERFLOW_EN.
module tb_input_port_fifo;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

`ifdef INPORT_UNDERFLOW_EN
    localparam logic UF_EXP = 1'b1;
`else
    localparam logic UF_EXP = 1'b0;
`endif

    input_port_fifo_if #(.DEPTH(16), .WIDTH(16)) bus ();

    input_port_fifo #(.DEPTH(16), .WIDTH(16)) dut (
        .CLK   (clk),
        .reset (reset),
        .port  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] q[$];

    initial begin
        reset        = 1'b1;
        bus.ext_valid = 1'b0;
        bus.ext_data  = '0;
        bus.rd_en     = 1'b0;
        step();
        step();
        check("ready_in_reset", bus.ext_ready, 1'b0);
        reset = 1'b0;
        #1;
        check("rst_ready", bus.ext_ready, 1'b1);
        check("rst_empty", bus.empty, 1'b1);
        check("rst_full", bus.full, 1'b0);
        check("rst_count", bus.count, 0);
        check("rst_getin", bus.getin, 16'h0000);
        check("rst_uflow", bus.underflow, 1'b0);

        // Two pushes, then one pop
        bus.ext_valid = 1'b1;
        bus.ext_data  = 16'h1234;
        step();
        check("lat1_getin", bus.getin, 16'h1234);
        bus.ext_data = 16'hABCD;
        step();
        bus.ext_valid = 1'b0;
        check("two_count", bus.count, 2);
        check("two_getin", bus.getin, 16'h1234);
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        check("pop1_getin", bus.getin, 16'hABCD);
        check("pop1_count", bus.count, 1);
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        check("drain_empty", bus.empty, 1'b1);

        // Fill to full, hold a 17th word
        bus.ext_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.ext_data = 16'(i);
            step();
        end
        check("fill_full", bus.full, 1'b1);
        check("fill_ready", bus.ext_ready, 1'b0);
        check("fill_count", bus.count, 16);
        bus.ext_data = 16'h0011;
        step();
        check("held_count", bus.count, 16);
        check("held_getin", bus.getin, 16'h0000);
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        check("popfull_count", bus.count, 15);
        check("popfull_getin", bus.getin, 16'h0001);
        step();
        bus.ext_valid = 1'b0;
        check("w17_count", bus.count, 16);
        bus.rd_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check("drain_order", bus.getin, (i == 16) ? 16'h0011 : 16'(i));
            step();
        end
        bus.rd_en = 1'b0;
        check("drain16_empty", bus.empty, 1'b1);

        // Random pop pattern across pointer wrap, scoreboard model
        begin
            int sent = 0;
            for (int cyc = 0; cyc < 400 && (sent < 40 || q.size() > 0); cyc++) begin
                logic push_m, pop_m;
                logic [15:0] d;
                d = 16'h0100 + sent[15:0];
                bus.ext_valid = (sent < 40);
                bus.ext_data  = d;
                bus.rd_en     = (sent >= 40) || ($urandom_range(0, 2) == 0);
                push_m = bus.ext_valid && (q.size() < 16);
                pop_m  = bus.rd_en && (q.size() > 0);
                step();
                if (pop_m) void'(q.pop_front());
                if (push_m) begin
                    q.push_back(d);
                    sent++;
                end
                check("rand_count", bus.count, q.size());
                check("rand_getin", bus.getin, (q.size() > 0) ? q[0] : 16'h0000);
            end
            check("rand_done", (sent == 40) && (q.size() == 0), 1'b1);
            bus.ext_valid = 1'b0;
            bus.rd_en     = 1'b0;
        end

        // Simultaneous push and pop at count=3
        bus.ext_valid = 1'b1;
        bus.ext_data = 16'h00A1; step();
        bus.ext_data = 16'h00A2; step();
        bus.ext_data = 16'h00A3; step();
        bus.ext_data = 16'h00A4;
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        check("pp_count", bus.count, 3);
        check("pp_getin", bus.getin, 16'h00A2);

        // Reset mid-stream at count=5 with valid and rd_en asserted
        bus.ext_data = 16'h00A5; step();
        bus.ext_data = 16'h00A6; step();
        bus.ext_valid = 1'b0;
        check("c5_count", bus.count, 5);
        reset = 1'b1;
        bus.ext_valid = 1'b1;
        bus.ext_data = 16'hBEEF;
        bus.rd_en = 1'b1;
        step();
        reset = 1'b0;
        bus.ext_valid = 1'b0;
        bus.rd_en = 1'b0;
        check("mrst_count", bus.count, 0);
        check("mrst_empty", bus.empty, 1'b1);
        check("mrst_getin", bus.getin, 16'h0000);
        check("mrst_uflow", bus.underflow, 1'b0);

        // Read while empty
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        check("uf_getin", bus.getin, 16'h0000);
        check("uf_count", bus.count, 0);
        check("uf_set", bus.underflow, UF_EXP);
        bus.ext_valid = 1'b1;
        bus.ext_data = 16'h5A5A;
        step();
        bus.ext_valid = 1'b0;
        check("uf_sticky", bus.underflow, UF_EXP);
        check("uf_push_getin", bus.getin, 16'h5A5A);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("uf_cleared", bus.underflow, 1'b0);
        check("final_empty", bus.empty, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/input_port_fifo.md
INPUT_PORT_FIFO -- requirements
Module: input_port_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of 16-bit entries; power of two, 2..64.
REQ-002 Parameter WIDTH, default 16, data word width; matches processor datapath.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port CLK, input, 1, clock; all state updates on rising edge.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port ext_data, input, WIDTH, word offered by external producer.
REQ-007 Port ext_valid, input, 1, producer has a word on ext_data.
REQ-008 Port ext_ready, output, 1, FIFO accepts a word this cycle.
REQ-009 Port rd_en, input, 1, processor consumes head word (IN instruction pushing getin onto stack).
REQ-010 Port getin, output, WIDTH, head word presented to processor stack-input mux.
REQ-011 Port empty, output, 1, no stored entries.
REQ-012 Port full, output, 1, DEPTH entries stored.
REQ-013 Port count, output, clog2(DEPTH)+1, number of stored entries.
REQ-014 Port underflow, output, 1, sticky read-while-empty error flag (see Configuration).

Function
REQ-015 Push SHALL occur on a rising edge when ext_valid=1 and ext_ready=1; ext_data written at wr_ptr, wr_ptr+1.
REQ-016 ext_ready SHALL be combinational: !full && !reset.
REQ-017 Pop SHALL occur on a rising edge when rd_en=1 and empty=0; rd_ptr+1.
REQ-018 rd_en while empty SHALL be ignored: no pointer/count change, getin stays 0.
REQ-019 getin SHALL equal the entry at rd_ptr when empty=0, and 16'h0000 when empty=1; combinational from registered state, zero-cycle read latency.
REQ-020 A pushed word SHALL appear on getin the cycle after the push edge (write-to-read latency 1); no same-cycle bypass.
REQ-021 Simultaneous push and pop with 0<count<DEPTH: both performed, count unchanged.
REQ-022 Pop at full: pop performed, push blocked by ext_ready=0 that cycle; count becomes DEPTH-1.
REQ-023 Push at empty with rd_en=1: push performed, pop ignored; count becomes 1.
REQ-024 Pointers SHALL wrap modulo DEPTH; ordering strictly first-in first-out across wrap.
REQ-025 count SHALL range 0..DEPTH; empty=(count==0); full=(count==DEPTH).
REQ-026 ext_data SHALL be sampled only on an accepted push; holding ext_valid=1 with ready low SHALL NOT drop or duplicate data.

Reset
REQ-027 While reset=1 at an edge: wr_ptr, rd_ptr, count cleared to 0; underflow cleared to 0; pushes and pops suppressed.
REQ-028 Outputs after reset: getin=16'h0000, empty=1, full=0, count=0, ext_ready=1 (0 while reset held), underflow=0.
REQ-029 Reset asserted mid-stream SHALL discard all stored entries; storage array contents need not be cleared.

Configuration
REQ-030 Macro INPORT_UNDERFLOW_EN: when defined, underflow SHALL set on any edge with rd_en=1 and empty=1 and stay set until reset.
REQ-031 Without INPORT_UNDERFLOW_EN, underflow SHALL be tied to 0; port remains present; all other behaviour identical.

Verification
REQ-032 Reset, then push 16'h1234, 16'hABCD on consecutive cycles, rd_en=0 -> count=2, getin=16'h1234; one rd_en pulse -> getin=16'hABCD, count=1.
REQ-033 Push 16 words 16'h0000..16'h000F with DEPTH=16 -> full=1, ext_ready=0, count=16; 17th word held on ext_data not accepted; pop once -> next cycle 17th word accepted, count=16.
REQ-034 Fill/drain 40 words with random pop pattern, DEPTH=16 -> output order equals input order across pointer wrap, count never exceeds 16.
REQ-035 count=3, push and pop same edge -> count stays 3, getin advances to second-oldest word.
REQ-036 Empty FIFO, rd_en=1 one cycle -> getin=0, count=0; underflow=1 with INPORT_UNDERFLOW_EN defined, 0 without; stays 1 until reset.
REQ-037 count=5, assert reset one cycle with ext_valid=1 and rd_en=1 -> next cycle count=0, empty=1, getin=0, underflow=0, no word accepted.
